// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory for the MEM stage: one arbiter-granted load or store at a time,
// completed LATENCY cycles after accept with a mem_ready pulse qualified by mem_err.
module data_mem_ctrl #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       datIn,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [1:0]              control,
    input  logic                    arbiter,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    mem_ready,
    output logic                    mem_err,
    output logic                    busy,
    output logic [DEPTH*DATA_W-1:0] tb_mem
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_store_q, is_store_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   wb_q, wb_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                accept;
    logic                misaligned;
    logic                out_of_range;
    logic                addr_err;
    logic [IDX_W-1:0]    idx;

    // Address checks always look at the latched request, never the live inputs.
    assign misaligned   = ((addr_q >> OFF_W) << OFF_W) != addr_q;
    assign out_of_range = (addr_q >> OFF_W) >= DEPTH_A;
    assign addr_err     = misaligned || out_of_range;
    assign idx          = addr_q[OFF_W +: IDX_W];
    assign accept       = arbiter && ((control == OP_LOAD) || (control == OP_STORE));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wb_d       = wb_q;
        err_d      = 1'b0;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_LOAD;
                    is_store_d = (control == OP_STORE);
                    addr_d     = addr;
                    data_d     = datIn;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    err_d   = addr_err;
                    if (addr_err) begin
                        if (!is_store_q) wb_d = '0;
                    end else if (is_store_q) begin
                        mem_d[idx] = data_q;
                    end else begin
                        wb_d = mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the memory array is reset too, because a reset must leave the image all-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wb_q       <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wb_q       <= wb_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

    assign wb_data   = wb_q;
    assign mem_ready = (state_q == DONE);
    assign mem_err   = err_q;
    assign busy      = (state_q != IDLE);

    for (genvar i = 0; i < DEPTH; i++) begin : g_img
        assign tb_mem[i*DATA_W +: DATA_W] = mem_q[i];
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three configurations driven in lockstep, each checked against
// an arithmetic model of the memory, the completion timing and the address-error rules.
module tb_data_mem_ctrl;
    localparam logic [1:0] C_IDLE  = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_STORE = 2'b10;
    localparam logic [1:0] C_RSVD  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] dat_in = '0;
    logic [63:0] addr = '0;
    logic [1:0]  control = C_IDLE;
    logic        arbiter = 1'b0;

    logic [63:0] wb_a, wb_b;
    logic [31:0] wb_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        err_a, err_b, err_c;
    logic        bsy_a, bsy_b, bsy_c;
    logic [64*64-1:0] img_a, img_b;
    logic [16*32-1:0] img_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_mem [3][64];
    logic [63:0] m_wb  [3];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(64), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .datIn(dat_in), .addr(addr), .control(control), .arbiter(arbiter),
        .wb_data(wb_a), .mem_ready(rdy_a), .mem_err(err_a), .busy(bsy_a), .tb_mem(img_a));
    data_mem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(64), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .datIn(dat_in), .addr(addr), .control(control), .arbiter(arbiter),
        .wb_data(wb_b), .mem_ready(rdy_b), .mem_err(err_b), .busy(bsy_b), .tb_mem(img_b));
    data_mem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(16), .LATENCY(2)) u_c (
        .clk(clk), .rst(rst), .datIn(dat_in[31:0]), .addr(addr[15:0]), .control(control),
        .arbiter(arbiter), .wb_data(wb_c), .mem_ready(rdy_c), .mem_err(err_c), .busy(bsy_c),
        .tb_mem(img_c));

    function automatic int cfg_dw(int k);    return (k == 2) ? 32 : 64; endfunction
    function automatic int cfg_aw(int k);    return (k == 2) ? 16 : 64; endfunction
    function automatic int cfg_depth(int k); return (k == 2) ? 16 : 64; endfunction
    function automatic int cfg_lat(int k);   return (k == 1) ? 1 : 2;   endfunction

    function automatic logic [63:0] mask(int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] dut_word(int k, int i);
        case (k)
            0:       return img_a[i*64 +: 64];
            1:       return img_b[i*64 +: 64];
            default: return {32'b0, img_c[i*32 +: 32]};
        endcase
    endfunction

    function automatic logic [63:0] dut_wb(int k);
        case (k)
            0:       return wb_a;
            1:       return wb_b;
            default: return {32'b0, wb_c};
        endcase
    endfunction

    // {busy, mem_ready, mem_err}
    function automatic logic [2:0] dut_flags(int k);
        case (k)
            0:       return {bsy_a, rdy_a, err_a};
            1:       return {bsy_b, rdy_b, err_b};
            default: return {bsy_c, rdy_c, err_c};
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_wb[k] = '0;
            for (int i = 0; i < 64; i++) m_mem[k][i] = '0;
        end
    endtask

    task automatic check_image(string tag);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < cfg_depth(k); i++)
                check($sformatf("%s img%0d[%0d]", tag, k, i), dut_word(k, i), m_mem[k][i]);
    endtask

    task automatic check_quiet(string tag);
        for (int k = 0; k < 3; k++) begin
            logic [2:0] f;
            f = dut_flags(k);
            check($sformatf("%s busy%0d", tag, k), 64'(f[2]), 64'd0);
            check($sformatf("%s rdy%0d", tag, k), 64'(f[1]), 64'd0);
            check($sformatf("%s err%0d", tag, k), 64'(f[0]), 64'd0);
        end
    endtask

    // Called just after a falling edge with all instances idle; returns after a falling edge.
    task automatic do_op(string tag, logic [1:0] op, logic [63:0] a, logic [63:0] d);
        logic        e_err  [3];
        int          e_idx  [3];
        logic [63:0] e_wdat [3];
        logic [63:0] old_wb [3];
        logic [63:0] new_wb [3];
        for (int k = 0; k < 3; k++) begin
            logic [63:0] at;
            logic [63:0] bytes;
            at        = a & mask(cfg_aw(k));
            bytes     = 64'(cfg_dw(k) / 8);
            e_err[k]  = ((at % bytes) != 0) || ((at / bytes) >= 64'(cfg_depth(k)));
            e_idx[k]  = e_err[k] ? 0 : int'(at / bytes);
            e_wdat[k] = d & mask(cfg_dw(k));
            old_wb[k] = m_wb[k];
            new_wb[k] = old_wb[k];
            if (op == C_LOAD) new_wb[k] = e_err[k] ? 64'd0 : m_mem[k][e_idx[k]];
        end
        control = op; arbiter = 1'b1; addr = a; dat_in = d;
        @(posedge clk);
        #1;
        // Live inputs change while busy; the latched request must be used.
        control = 2'($urandom); arbiter = 1'b1;
        addr = {$urandom, $urandom}; dat_in = {$urandom, $urandom};
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int L;
                logic [2:0] f;
                L = cfg_lat(k);
                f = dut_flags(k);
                check($sformatf("%s c%0d busy%0d", tag, c, k), 64'(f[2]), 64'(c <= L));
                check($sformatf("%s c%0d rdy%0d", tag, c, k), 64'(f[1]), 64'(c == L));
                check($sformatf("%s c%0d err%0d", tag, c, k), 64'(f[0]), 64'((c == L) && e_err[k]));
                check($sformatf("%s c%0d wb%0d", tag, c, k), dut_wb(k),
                      (c >= L) ? new_wb[k] : old_wb[k]);
                if (c == L && op == C_STORE && !e_err[k])
                    check($sformatf("%s c%0d wr%0d", tag, c, k), dut_word(k, e_idx[k]), e_wdat[k]);
            end
            if (c == 1) begin
                control = C_IDLE; arbiter = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            m_wb[k] = new_wb[k];
            if (op == C_STORE && !e_err[k]) m_mem[k][e_idx[k]] = e_wdat[k];
        end
        check_image(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        for (int k = 0; k < 3; k++) check($sformatf("reset wb%0d", k), dut_wb(k), 64'd0);
        check_image("reset");
        rst = 1'b0;
        @(negedge clk);

        do_op("st10", C_STORE, 64'h10, 64'hDEADBEEF_00000001);
        do_op("ld10", C_LOAD, 64'h10, 64'h0);
        do_op("st18", C_STORE, 64'h18, 64'h0123_4567_89AB_CDEF);

        control = C_LOAD; addr = 64'h10; arbiter = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_quiet("arb0");
        end
        do_op("ld10arb", C_LOAD, 64'h10, 64'h0);

        control = C_RSVD; arbiter = 1'b1; addr = 64'h18;
        repeat (4) begin
            @(negedge clk);
            check_quiet("ctl11");
        end
        control = C_IDLE;
        @(negedge clk);

        do_op("ld13", C_LOAD, 64'h13, 64'h0);
        do_op("st200", C_STORE, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            logic [1:0]  op;
            case ($urandom_range(0, 3))
                0:       a = 64'($urandom_range(0, 15)) << 3;
                1:       a = 64'($urandom_range(0, 15)) << 2;
                2:       a = 64'($urandom_range(0, 63)) << 3;
                default: a = {32'b0, $urandom};
            endcase
            op = ($urandom_range(0, 1) == 0) ? C_LOAD : C_STORE;
            do_op($sformatf("rnd%0d", n), op, a, {$urandom, $urandom});
        end

        // Asynchronous reset half a cycle after a store to 0x8 is accepted.
        control = C_STORE; arbiter = 1'b1; addr = 64'h8; dat_in = 64'hCAFE_F00D_1234_5678;
        @(posedge clk);
        #1;
        control = C_IDLE; arbiter = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_quiet("rstmid");
        for (int k = 0; k < 3; k++) check($sformatf("rstmid wb%0d", k), dut_wb(k), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_quiet("postrst");
        end
        check_image("postrst");

        do_op("st3c", C_STORE, 64'h3C, 64'h5555_AAAA_0F0F_F0F0);
        do_op("ld3c", C_LOAD, 64'h3C, 64'h0);
        do_op("st10b", C_STORE, 64'h10, 64'hDEADBEEF_00000001);
        do_op("ld10b", C_LOAD, 64'h10, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
